pipe_issue_ctrl: RTL and testbench



---
 rtl/pipe_issue_pkg.sv | 31 +++
 rtl/pipe_res_fifo.sv | 57 +++++
 rtl/pipe_issue_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_issue_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_issue_pkg
// Brief    : Shared opcodes, shadow-model constants, FSM states and tag type
//            for the pipeline issue controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package pipe_issue_pkg;

   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_SUB    = 2'b01;
   localparam logic [1:0] OP_LOAD   = 2'b10;
   localparam logic [1:0] OP_NOP    = 2'b11;
   localparam logic [7:0] NOP_INSTR = 8'hC0;

   localparam logic [7:0] REGA_INIT = 8'd10;
   localparam logic [7:0] REGB_INIT = 8'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] op;
   } tag_t;

endpackage
`default_nettype wire

// File: rtl/pipe_res_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_res_fifo
// Brief    : Synchronous FIFO with head-of-queue output and occupancy count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pipe_res_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     not_empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam logic [c_aw:0]   c_full    = (c_aw+1)'(DEPTH);
   localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A pop frees the slot the same cycle, so push into a full FIFO is legal with pop
   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count != c_full) || w_do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + c_ptr_one;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
         r_count <= r_count + (c_aw+1)'(w_do_push) - (c_aw+1)'(w_do_pop);
      end
   end

   assign head      = r_mem[r_rd_ptr];
   assign not_empty = (r_count != '0);
   assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_issue_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_issue_ctrl
// Brief    : Program RAM driven instruction issuer with credit flow control and
//            result capture FIFO. Define ISSUE_SCORE_EN for the shadow checker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pipe_issue_ctrl
   import pipe_issue_pkg::*;
#(
   parameter int PROG_DEPTH = 16,
   parameter int PIPE_LAT   = 4,
   parameter int DATA_LAT   = 2,
   parameter int RES_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          prog_we,
   input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
   input  logic [15:0]                   prog_wdata,
   input  logic [$clog2(PROG_DEPTH):0]   prog_len,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic [7:0]                    instr_o,
   output logic [7:0]                    data_o,
   input  logic [7:0]                    pipe_result,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [7:0]                    res_data,
   output logic [1:0]                    res_op,
   output logic [7:0]                    err_count
);

   localparam int c_aw = $clog2(PROG_DEPTH);
   localparam int c_cw = $clog2(RES_DEPTH) + 1;
   localparam logic [c_cw:0]   c_res_depth = (c_cw+1)'(RES_DEPTH);
   localparam logic [c_aw:0]   c_pc_one    = (c_aw+1)'(1);
   localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [15:0]     r_prog [PROG_DEPTH];
   logic [c_aw:0]   r_pc;
   logic [c_aw:0]   r_len;
   logic [c_cw-1:0] r_inflight;
   logic            r_zero_done;
   logic [7:0]      r_instr;
   logic [7:0]      r_data;
   tag_t            r_tag [PIPE_LAT+1];
   logic            r_dly_ld  [DATA_LAT];
   logic [7:0]      r_dly_val [DATA_LAT];

   logic [c_cw-1:0] w_fifo_count;
   logic [c_cw:0]   w_used;
   logic [15:0]     w_word;
   logic [9:0]      w_head;
   tag_t            w_tag_in;
   logic            w_accept;
   logic            w_credit_ok;
   logic            w_issue;
   logic            w_last;
   logic            w_capture;
   logic            w_pop;
   logic            w_drain_done;

   assign w_accept     = (r_state == IDLE) && start;
   assign w_used       = {1'b0, w_fifo_count} + {1'b0, r_inflight};
   assign w_credit_ok  = (w_used < c_res_depth);
   assign w_issue      = (r_state == ISSUE) && w_credit_ok;
   assign w_last       = (r_pc == (r_len - c_pc_one));
   assign w_word       = r_prog[r_pc[c_aw-1:0]];
   assign w_capture    = r_tag[PIPE_LAT].valid;
   assign w_pop        = res_valid && res_ready;
   // Last result is the one whose capture takes in-flight from 1 to 0
   assign w_drain_done = (r_state == DRAIN) &&
                         ((r_inflight == '0) || (w_capture && (r_inflight == c_cnt_one)));

   always_comb begin
      w_tag_in       = '0;
      w_tag_in.valid = w_issue && (w_word[7:6] != OP_NOP);
      w_tag_in.op    = w_issue ? w_word[7:6] : OP_NOP;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start && (prog_len != '0)) w_state_nxt = ISSUE;
         ISSUE:   if (w_issue && w_last)         w_state_nxt = DRAIN;
         DRAIN:   if (w_drain_done)              w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (prog_we && (r_state == IDLE)) r_prog[prog_addr] <= prog_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_pc        <= '0;
         r_len       <= '0;
         r_inflight  <= '0;
         r_zero_done <= 1'b0;
         r_instr     <= NOP_INSTR;
         r_data      <= '0;
         for (int k = 0; k <= PIPE_LAT; k++) r_tag[k] <= '0;
         for (int k = 0; k < DATA_LAT; k++) begin
            r_dly_ld[k]  <= 1'b0;
            r_dly_val[k] <= '0;
         end
      end else begin
         r_state     <= w_state_nxt;
         r_zero_done <= w_accept && (prog_len == '0);
         if (w_accept) begin
            r_pc  <= '0;
            r_len <= prog_len;
         end else if (w_issue) begin
            r_pc <= r_pc + c_pc_one;
         end
         r_inflight <= r_inflight + c_cw'(w_tag_in.valid) - c_cw'(w_capture);
         r_instr    <= w_issue ? w_word[7:0] : NOP_INSTR;

         // Stage 0 lines up with the cycle the instruction is on instr_o
         r_tag[0] <= w_tag_in;
         for (int k = 1; k <= PIPE_LAT; k++) r_tag[k] <= r_tag[k-1];

         r_dly_ld[0]  <= w_tag_in.valid && (w_tag_in.op == OP_LOAD);
         r_dly_val[0] <= w_word[15:8];
         for (int k = 1; k < DATA_LAT; k++) begin
            r_dly_ld[k]  <= r_dly_ld[k-1];
            r_dly_val[k] <= r_dly_val[k-1];
         end
         if (r_dly_ld[DATA_LAT-1]) r_data <= r_dly_val[DATA_LAT-1];
      end
   end

   pipe_res_fifo #(
      .WIDTH (10),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_capture),
      .push_data ({r_tag[PIPE_LAT].op, pipe_result}),
      .pop       (w_pop),
      .head      (w_head),
      .not_empty (res_valid),
      .count     (w_fifo_count)
   );

`ifdef ISSUE_SCORE_EN
   logic [7:0] r_opnd [PIPE_LAT+1];
   logic [7:0] r_err;
   logic [7:0] w_expect;

   always_comb begin
      w_expect = r_opnd[PIPE_LAT];
      case (r_tag[PIPE_LAT].op)
         OP_ADD:  w_expect = REGA_INIT + REGB_INIT;
         OP_SUB:  w_expect = REGA_INIT - REGB_INIT;
         default: w_expect = r_opnd[PIPE_LAT];
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k <= PIPE_LAT; k++) r_opnd[k] <= '0;
         r_err <= '0;
      end else begin
         r_opnd[0] <= w_word[15:8];
         for (int k = 1; k <= PIPE_LAT; k++) r_opnd[k] <= r_opnd[k-1];
         if (w_accept) begin
            r_err <= '0;
         end else if (w_capture && (pipe_result != w_expect) && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
         end
      end
   end

   assign err_count = r_err;
`else
   assign err_count = 8'h00;
`endif

   assign busy     = (r_state != IDLE);
   assign done     = r_zero_done || w_drain_done;
   assign instr_o  = r_instr;
   assign data_o   = r_data;
   assign res_data = w_head[7:0];
   assign res_op   = w_head[9:8];

endmodule
`default_nettype wire

// File: tb/tb_pipe_issue_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pipe_issue_ctrl
// Brief    : Scoreboard bench with a behavioural processor model for
//            pipe_issue_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pipe_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [15:0] prog_wdata = '0;
   logic [4:0]  prog_len = '0;
   logic        start = 1'b0;
   logic [7:0]  pipe_result = '0;
   logic        res_ready = 1'b0;
   logic        busy, done, res_valid;
   logic [7:0]  instr_o, data_o, res_data, err_count;
   logic [1:0]  res_op;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int issued = 0;
   int popped = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_issue_cyc = 0;
   int rdy_mode = 1;

   logic [9:0] exp_q [$];
   logic [7:0] instr_hist [64];
   logic [7:0] data_hist [64];
   logic [1:0] p_op [16];
   logic [7:0] p_opnd [16];
   logic [5:0] p_lo [16];

   pipe_issue_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_wdata  (prog_wdata),
      .prog_len    (prog_len),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .instr_o     (instr_o),
      .data_o      (data_o),
      .pipe_result (pipe_result),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_op      (res_op),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected processor writeback for one program entry
   function automatic logic [9:0] expv_of(input logic [1:0] op, input logic [7:0] opnd);
      case (op)
         2'b00:   return {op, 8'd15};
         2'b01:   return {op, 8'd5};
         default: return {op, opnd};
      endcase
   endfunction

   // Processor: result for the instruction seen 4 cycles ago, LOAD uses data_in seen 2 cycles ago
   initial begin
      for (int i = 0; i < 64; i++) begin
         instr_hist[i] = 8'hC0;
         data_hist[i]  = 8'h00;
      end
   end

   always @(negedge clk) begin : proc_model
      logic [7:0] ins;
      instr_hist[cyc & 63] = instr_o;
      data_hist[cyc & 63]  = data_o;
      ins = instr_hist[(cyc + 60) & 63];
      case (ins[7:6])
         2'b00:   pipe_result = 8'd15;
         2'b01:   pipe_result = 8'd5;
         2'b10:   pipe_result = data_hist[(cyc + 62) & 63];
         default: pipe_result = 8'($urandom);
      endcase
   end

   always @(negedge clk) begin : monitor
      logic [9:0] e;
      if (instr_o[7:6] != 2'b11) begin
         issued++;
         last_issue_cyc = cyc;
      end
      if (busy) chk("credit", 32'(issued - popped <= 4), 32'd1);
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (res_valid && res_ready) begin
         popped++;
         if (exp_q.size() == 0) begin
            chk("extra_result", {22'd0, res_op, res_data}, 32'h3ff);
         end else begin
            e = exp_q.pop_front();
            chk("res_data", 32'(res_data), 32'(e[7:0]));
            chk("res_op", 32'(res_op), 32'(e[9:8]));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   task automatic chk_reset_vals(input string nm);
      @(negedge clk);
      chk({nm, "_busy"},      32'(busy),      32'd0);
      chk({nm, "_done"},      32'(done),      32'd0);
      chk({nm, "_instr"},     32'(instr_o),   32'hC0);
      chk({nm, "_data"},      32'(data_o),    32'd0);
      chk({nm, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({nm, "_res_data"},  32'(res_data),  32'd0);
      chk({nm, "_res_op"},    32'(res_op),    32'd0);
      chk({nm, "_err"},       32'(err_count), 32'd0);
   endtask

   task automatic load_prog(input int len);
      for (int i = 0; i < len; i++) begin
         prog_we    = 1'b1;
         prog_addr  = 4'(i);
         prog_wdata = {p_opnd[i], p_op[i], p_lo[i]};
         tick();
      end
      prog_we = 1'b0;
   endtask

   task automatic start_prog(input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(expv_of(p_op[i], p_opnd[i]));
      done_cnt = 0;
      prog_len = 5'(len);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic finish_run(input string nm);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk({nm, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
      chk({nm, "_done_lat"}, 32'(done_cyc - last_issue_cyc), 32'd4);
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      repeat (3) tick();
      chk({nm, "_done_once"}, 32'(done_cnt), 32'd1);
      chk({nm, "_busy_end"}, 32'(busy), 32'd0);
      chk({nm, "_all_results"}, 32'(exp_q.size()), 32'd0);
      chk({nm, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   task automatic set_op(input int i, input logic [1:0] op, input logic [7:0] opnd);
      p_op[i]   = op;
      p_opnd[i] = opnd;
      p_lo[i]   = 6'($urandom);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int base;
      int n;
      logic found;

      chk_reset_vals("reset");
      tick();
      reset = 1'b1;
      tick();

      // Basic ADD, SUB, LOAD 0x14
      rdy_mode = 1;
      set_op(0, 2'b00, 8'h00);
      set_op(1, 2'b01, 8'h00);
      set_op(2, 2'b10, 8'h14);
      load_prog(3);
      start_prog(3);
      finish_run("basic");

      // Credit stall with consumer blocked
      rdy_mode  = 0;
      res_ready = 1'b0;
      for (int i = 0; i < 6; i++) set_op(i, 2'b00, 8'($urandom));
      load_prog(6);
      base = issued;
      start_prog(6);
      repeat (20) tick();
      @(negedge clk);
      chk("stall_issued", 32'(issued - base), 32'd4);
      chk("stall_instr", 32'(instr_o), 32'hC0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_res_valid", 32'(res_valid), 32'd1);
      rdy_mode = 1;
      finish_run("stall");
      chk("stall_issued_total", 32'(issued - base), 32'd6);

      // LOAD operand timing
      set_op(0, 2'b10, 8'hA5);
      load_prog(1);
      start_prog(1);
      found = 1'b0;
      n = 0;
      while (!found && n < 50) begin
         @(negedge clk);
         if (instr_o[7:6] == 2'b10) found = 1'b1;
         n++;
      end
      chk("load_seen", 32'(found), 32'd1);
      @(negedge clk);
      chk("load_data_t1", 32'(data_o), 32'h14);
      @(negedge clk);
      chk("load_data_t2", 32'(data_o), 32'hA5);
      finish_run("load");

      // Zero-length program
      tick();
      base     = issued;
      n        = popped;
      done_cnt = 0;
      prog_len = 5'd0;
      start    = 1'b1;
      @(negedge clk);
      chk("zero_done_pre", 32'(done), 32'd0);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("zero_done_end", 32'(done), 32'd0);
      repeat (4) @(negedge clk);
      chk("zero_res_valid", 32'(res_valid), 32'd0);
      chk("zero_no_issue", 32'(issued - base), 32'd0);
      chk("zero_no_pop", 32'(popped - n), 32'd0);
      chk("zero_done_once", 32'(done_cnt), 32'd1);

      // start and prog_we during a run are ignored
      tick();
      set_op(0, 2'b00, 8'h00);
      set_op(1, 2'b10, 8'h33);
      set_op(2, 2'b01, 8'h00);
      set_op(3, 2'b00, 8'h00);
      load_prog(4);
      start_prog(4);
      tick();
      start      = 1'b1;
      prog_len   = 5'd1;
      prog_we    = 1'b1;
      prog_addr  = 4'd0;
      prog_wdata = {8'h77, 2'b10, 6'd0};
      tick();
      start   = 1'b0;
      prog_we = 1'b0;
      finish_run("ignore1");
      start_prog(4);
      finish_run("ignore2");

      // Reset in the middle of a run
      for (int i = 0; i < 5; i++) set_op(i, 2'($urandom_range(0, 2)), 8'($urandom));
      load_prog(5);
      start_prog(5);
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
      issued = 0;
      popped = 0;
      chk_reset_vals("midreset");
      tick();
      reset = 1'b1;
      tick();
      start_prog(5);
      finish_run("after_reset");

      // Randomised programs and consumer back-pressure
      for (int r = 0; r < 25; r++) begin
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) set_op(i, 2'($urandom_range(0, 2)), 8'($urandom));
         rdy_mode = $urandom_range(1, 2);
         load_prog(n);
         start_prog(n);
         finish_run("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
